// File: rtl/sprite_dispatcher_pkg.sv
// sprite_dispatcher_pkg
//   Shared widths and types for the sprite broadcast bus. The stream-processor
//   array imports the same bundle widths so both ends of the bus agree.
//   Contents: pixel/row/bundle widths, band/depth/column widths, the
//   dispatcher state enum and the latched command-field struct.
package sprite_dispatcher_pkg;

  localparam int PIXEL_W    = 8;
  localparam int ROW_PIXELS = 16;
  localparam int ROW_W      = PIXEL_W * ROW_PIXELS;  // 128
  localparam int BUNDLE_W   = 2 * ROW_W;             // 256: even row low, odd row high
  localparam int BAND_W     = 4;
  localparam int Z_W        = 8;
  localparam int X_W        = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD0  = 2'd1,
    RD1  = 2'd2,
    CAP  = 2'd3
  } state_e;

  // Broadcast fields captured at command accept and held for the whole sprite.
  typedef struct packed {
    logic [X_W-1:0]    start_x;
    logic [Z_W-1:0]    position_z;
    logic [BAND_W-1:0] band_base;
  } cmd_fields_t;

endpackage

// File: rtl/sprite_dispatcher.sv
// sprite_dispatcher
//   Transmit side of the stream-processor broadcast bus. Accepts one sprite
//   command, reads the texture two rows per band from texture memory, packs
//   each row pair into a 256-bit bundle and broadcasts it for one cycle.
//   Three cycles per band: RD0 (read even row), RD1 (read odd row, capture
//   even row), CAP (register bundle; strobe appears next cycle).
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   i_cmd_valid / o_cmd_ready  command handshake
//   i_cmd_tex_base             word address of sprite row 0
//   i_cmd_start_x              left column within the band
//   i_cmd_position_z           depth (0 = clear pass, forwarded as-is)
//   i_cmd_band_base            first target band
//   o_mem_rd_en / o_mem_addr   texture read; i_mem_data valid one cycle later
//   o_ena                      one-cycle bundle strobe
//   o_texture_data             {odd row, even row}
//   o_start_x/o_position_z     broadcast fields
//   o_band                     target band for this bundle (wraps mod 16)
//   o_done                     pulses with the final bundle
//   o_busy                     high from accept until the final bundle
// TEX_ROWS must be even and at least 2.
module sprite_dispatcher
  import sprite_dispatcher_pkg::*;
#(
  parameter int TEX_ROWS   = 16,
  parameter int MEM_ADDR_W = 12
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_cmd_valid,
  output logic                  o_cmd_ready,
  input  logic [MEM_ADDR_W-1:0] i_cmd_tex_base,
  input  logic [X_W-1:0]        i_cmd_start_x,
  input  logic [Z_W-1:0]        i_cmd_position_z,
  input  logic [BAND_W-1:0]     i_cmd_band_base,
  output logic                  o_mem_rd_en,
  output logic [MEM_ADDR_W-1:0] o_mem_addr,
  input  logic [ROW_W-1:0]      i_mem_data,
  output logic                  o_ena,
  output logic [BUNDLE_W-1:0]   o_texture_data,
  output logic [X_W-1:0]        o_start_x,
  output logic [Z_W-1:0]        o_position_z,
  output logic [BAND_W-1:0]     o_band,
  output logic                  o_done,
  output logic                  o_busy
);

  localparam int NBANDS = TEX_ROWS / 2;
  localparam int KW     = (NBANDS > 1) ? $clog2(NBANDS) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(NBANDS - 1);

  state_e                r_state, w_state_nxt;
  logic [KW-1:0]         r_k;       // band pair counter
  logic [MEM_ADDR_W-1:0] r_base;
  cmd_fields_t           r_cmd;
  logic [ROW_W-1:0]      r_row0;    // even row of the current pair
  logic [MEM_ADDR_W-1:0] w_pair_addr;
  logic                  w_last;
  logic                  w_accept;

  // Address arithmetic is MEM_ADDR_W wide so it wraps naturally.
  assign w_pair_addr = r_base + (MEM_ADDR_W'(r_k) << 1);
  assign w_last      = (r_k == K_LAST);

  assign o_busy      = (r_state != IDLE);
  assign o_cmd_ready = !o_busy;
  assign w_accept    = o_cmd_ready && i_cmd_valid;

  always_comb begin
    w_state_nxt = r_state;
    o_mem_rd_en = 1'b0;
    o_mem_addr  = '0;
    unique case (r_state)
      IDLE: if (w_accept) w_state_nxt = RD0;
      RD0: begin
        o_mem_rd_en = 1'b1;
        o_mem_addr  = w_pair_addr;
        w_state_nxt = RD1;
      end
      RD1: begin
        o_mem_rd_en = 1'b1;
        o_mem_addr  = w_pair_addr + MEM_ADDR_W'(1);
        w_state_nxt = CAP;
      end
      CAP:     w_state_nxt = w_last ? IDLE : RD0;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state        <= IDLE;
      r_k            <= '0;
      r_base         <= '0;
      r_cmd          <= '0;
      r_row0         <= '0;
      o_ena          <= 1'b0;
      o_done         <= 1'b0;
      o_texture_data <= '0;
      o_start_x      <= '0;
      o_position_z   <= '0;
      o_band         <= '0;
    end else begin
      r_state <= w_state_nxt;
      o_ena   <= 1'b0;
      o_done  <= 1'b0;
      unique case (r_state)
        IDLE: if (w_accept) begin
          r_base           <= i_cmd_tex_base;
          r_cmd.start_x    <= i_cmd_start_x;
          r_cmd.position_z <= i_cmd_position_z;
          r_cmd.band_base  <= i_cmd_band_base;
          r_k              <= '0;
        end
        // Data for the RD0 read arrives while in RD1.
        RD1: r_row0 <= i_mem_data;
        // Odd row arrives while in CAP; the bundle is registered here so the
        // strobe and its payload appear together on the next cycle.
        CAP: begin
          o_texture_data <= {i_mem_data, r_row0};
          o_start_x      <= r_cmd.start_x;
          o_position_z   <= r_cmd.position_z;
          o_band         <= r_cmd.band_base + BAND_W'(r_k);
          o_ena          <= 1'b1;
          o_done         <= w_last;
          if (!w_last) r_k <= r_k + KW'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sprite_dispatcher.sv
// tb_sprite_dispatcher
//   Bench for sprite_dispatcher with TEX_ROWS = 4. A cycle-indexed reference
//   model predicts, from each accepted command, the exact cycle and address of
//   every texture read and the cycle and contents of every bundle; a monitor
//   compares the DUT against it every cycle. Directed table vectors, queued
//   back-to-back commands, a mid-sprite reset and random commands drive it.
module tb_sprite_dispatcher;
  import sprite_dispatcher_pkg::*;

  localparam int TR = 4;
  localparam int NB = TR / 2;
  localparam int AW = 12;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              i_cmd_valid = 1'b0;
  logic              o_cmd_ready;
  logic [AW-1:0]     i_cmd_tex_base = '0;
  logic [3:0]        i_cmd_start_x = '0;
  logic [7:0]        i_cmd_position_z = '0;
  logic [3:0]        i_cmd_band_base = '0;
  logic              o_mem_rd_en;
  logic [AW-1:0]     o_mem_addr;
  logic [127:0]      i_mem_data = '0;
  logic              o_ena;
  logic [255:0]      o_texture_data;
  logic [3:0]        o_start_x;
  logic [7:0]        o_position_z;
  logic [3:0]        o_band;
  logic              o_done;
  logic              o_busy;

  sprite_dispatcher #(.TEX_ROWS(TR), .MEM_ADDR_W(AW)) dut (
    .clk(clk), .reset(reset),
    .i_cmd_valid(i_cmd_valid), .o_cmd_ready(o_cmd_ready),
    .i_cmd_tex_base(i_cmd_tex_base), .i_cmd_start_x(i_cmd_start_x),
    .i_cmd_position_z(i_cmd_position_z), .i_cmd_band_base(i_cmd_band_base),
    .o_mem_rd_en(o_mem_rd_en), .o_mem_addr(o_mem_addr), .i_mem_data(i_mem_data),
    .o_ena(o_ena), .o_texture_data(o_texture_data), .o_start_x(o_start_x),
    .o_position_z(o_position_z), .o_band(o_band), .o_done(o_done), .o_busy(o_busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Texture memory: one-cycle read latency.
  logic [127:0] mem [0:4095];
  always @(posedge clk) if (o_mem_rd_en) i_mem_data <= mem[o_mem_addr];

  typedef struct {
    int           cyc;
    logic [255:0] data;
    logic [3:0]   sx;
    logic [7:0]   z;
    logic [3:0]   band;
    logic         done;
  } ena_t;
  typedef struct {
    int            cyc;
    logic [AW-1:0] addr;
  } rd_t;

  ena_t exp_ena[$];
  rd_t  exp_rd[$];
  ena_t obs_ena[$];
  rd_t  obs_rd[$];
  int   acc_q[$];
  int   busy_lo = 0, busy_hi = -1;

  int checks = 0;
  int fails  = 0;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- reference model + monitor ----------------
  ena_t          m_e;
  rd_t           m_r;
  logic [AW-1:0] m_a;
  logic          m_busy;

  always @(negedge clk) begin
    if (o_ena) obs_ena.push_back('{cyc, o_texture_data, o_start_x, o_position_z, o_band, o_done});
    if (reset) begin
      exp_ena.delete();
      exp_rd.delete();
      busy_hi = -1;
    end else begin
      if (o_mem_rd_en) obs_rd.push_back('{cyc, o_mem_addr});
      m_busy = (cyc >= busy_lo) && (cyc <= busy_hi);
      chk("busy", o_busy, m_busy);
      chk("cmd_ready", o_cmd_ready, !m_busy);

      if (o_mem_rd_en) begin
        chk("read_expected", exp_rd.size() > 0, 1'b1);
        if (exp_rd.size() > 0) begin
          m_r = exp_rd.pop_front();
          chk("read_cycle", cyc, m_r.cyc);
          chk("read_addr", o_mem_addr, m_r.addr);
        end
      end else if (exp_rd.size() > 0 && exp_rd[0].cyc <= cyc) begin
        chk("read_present", o_mem_rd_en, 1'b1);
        m_r = exp_rd.pop_front();
      end

      if (o_ena) begin
        chk("ena_expected", exp_ena.size() > 0, 1'b1);
        if (exp_ena.size() > 0) begin
          m_e = exp_ena.pop_front();
          chk("ena_cycle", cyc, m_e.cyc);
          chk("bundle", o_texture_data, m_e.data);
          chk("start_x", o_start_x, m_e.sx);
          chk("position_z", o_position_z, m_e.z);
          chk("band", o_band, m_e.band);
          chk("done", o_done, m_e.done);
        end
      end else if (exp_ena.size() > 0 && exp_ena[0].cyc <= cyc) begin
        chk("ena_present", o_ena, 1'b1);
        m_e = exp_ena.pop_front();
      end
      if (o_done) chk("done_with_ena", o_ena, 1'b1);

      // A command accepted this cycle: rows 2k/2k+1 are read at +1+3k/+2+3k,
      // and band k is broadcast at +4+3k.
      if (i_cmd_valid && o_cmd_ready) begin
        acc_q.push_back(cyc);
        busy_lo = cyc + 1;
        busy_hi = cyc + 3 * NB;
        for (int k = 0; k < NB; k++) begin
          m_a = i_cmd_tex_base + AW'(2 * k);
          exp_rd.push_back('{cyc + 1 + 3 * k, m_a});
          exp_rd.push_back('{cyc + 2 + 3 * k, m_a + AW'(1)});
          exp_ena.push_back('{cyc + 4 + 3 * k, {mem[m_a + AW'(1)], mem[m_a]},
                              i_cmd_start_x, i_cmd_position_z,
                              i_cmd_band_base + 4'(k), (k == NB - 1)});
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic wait_ready();
    for (int t = 0; t < 40; t++) begin
      if (o_cmd_ready) break;
      @(posedge clk); #1;
    end
    chk("ready_within_bound", o_cmd_ready, 1'b1);
  endtask

  task automatic set_cmd(input logic [AW-1:0] b, input logic [3:0] x,
                         input logic [7:0] z, input logic [3:0] bb);
    i_cmd_tex_base   = b;
    i_cmd_start_x    = x;
    i_cmd_position_z = z;
    i_cmd_band_base  = bb;
  endtask

  // Returns at #1 into the cycle after the accept.
  task automatic send(input logic [AW-1:0] b, input logic [3:0] x,
                      input logic [7:0] z, input logic [3:0] bb);
    @(posedge clk); #1;
    set_cmd(b, x, z, bb);
    i_cmd_valid = 1'b1;
    wait_ready();
    @(posedge clk); #1;
    i_cmd_valid = 1'b0;
  endtask

  function automatic logic [127:0] row_of(input logic [7:0] p, input logic zm);
    return zm ? {8{8'h00, p}} : {16{p}};
  endfunction

  typedef struct {
    logic [AW-1:0] base;
    logic [3:0]    sx;
    logic [7:0]    z;
    logic [3:0]    bb;
    logic          zmix;      // interleave zero pixels into each row
    logic [7:0]    px [4];    // pixel byte of rows 0..3
    logic [AW-1:0] ea [4];    // expected read addresses
    logic [3:0]    eb [2];    // expected bands
  } vec_t;

  vec_t vt [3];
  int e0, r0, a0, ac, nd;
  logic [255:0] exp_bundle;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vt[0] = '{12'h100, 4'd3, 8'd5, 4'd2, 1'b0, '{8'h01, 8'h02, 8'h03, 8'h04},
              '{12'h100, 12'h101, 12'h102, 12'h103}, '{4'd2, 4'd3}};
    vt[1] = '{12'hFFE, 4'd0, 8'd9, 4'd15, 1'b0, '{8'h11, 8'h22, 8'h33, 8'h44},
              '{12'hFFE, 12'hFFF, 12'h000, 12'h001}, '{4'd15, 4'd0}};
    vt[2] = '{12'h200, 4'd15, 8'd0, 4'd7, 1'b1, '{8'h00, 8'h5A, 8'h00, 8'hC3},
              '{12'h200, 12'h201, 12'h202, 12'h203}, '{4'd7, 4'd8}};
    for (int i = 0; i < 4096; i++) mem[i] = '0;

    // Reset and idle.
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    chk("rst_texture_data", o_texture_data, 256'd0);
    chk("rst_band", o_band, 4'd0);
    chk("rst_start_x", o_start_x, 4'd0);
    chk("rst_position_z", o_position_z, 8'd0);
    chk("rst_mem_addr", o_mem_addr, 12'd0);
    for (int i = 0; i < 10; i++) begin
      chk("idle_ready", o_cmd_ready, 1'b1);
      chk("idle_ena", o_ena, 1'b0);
      chk("idle_rd_en", o_mem_rd_en, 1'b0);
      chk("idle_done", o_done, 1'b0);
      chk("idle_busy", o_busy, 1'b0);
      @(posedge clk); #1;
    end

    // Table-driven directed sprites.
    for (int v = 0; v < 3; v++) begin
      for (int r = 0; r < 4; r++) mem[vt[v].ea[r]] = row_of(vt[v].px[r], vt[v].zmix);
      e0 = obs_ena.size(); r0 = obs_rd.size(); a0 = acc_q.size();
      send(vt[v].base, vt[v].sx, vt[v].z, vt[v].bb);
      repeat (10) @(posedge clk);
      #1;
      chk("tbl_bundles", obs_ena.size() - e0, 2);
      chk("tbl_reads", obs_rd.size() - r0, 4);
      if (obs_ena.size() - e0 == 2 && obs_rd.size() - r0 == 4 && acc_q.size() > a0) begin
        ac = acc_q[a0];
        for (int r = 0; r < 4; r++) begin
          chk("tbl_rd_addr", obs_rd[r0 + r].addr, vt[v].ea[r]);
          chk("tbl_rd_cycle", obs_rd[r0 + r].cyc - ac, (r / 2) * 3 + 1 + (r % 2));
        end
        for (int b = 0; b < 2; b++) begin
          exp_bundle = {row_of(vt[v].px[2 * b + 1], vt[v].zmix), row_of(vt[v].px[2 * b], vt[v].zmix)};
          chk("tbl_latency", obs_ena[e0 + b].cyc - ac, (b == 0) ? 4 : 7);
          chk("tbl_bundle", obs_ena[e0 + b].data, exp_bundle);
          chk("tbl_band", obs_ena[e0 + b].band, vt[v].eb[b]);
          chk("tbl_start_x", obs_ena[e0 + b].sx, vt[v].sx);
          chk("tbl_z", obs_ena[e0 + b].z, vt[v].z);
          chk("tbl_done", obs_ena[e0 + b].done, b == 1);
        end
      end
    end

    for (int i = 0; i < 4096; i++) mem[i] = {$urandom, $urandom, $urandom, $urandom};

    // Two queued commands with valid held high throughout.
    e0 = obs_ena.size(); r0 = obs_rd.size(); a0 = acc_q.size();
    @(posedge clk); #1;
    set_cmd(12'h300, 4'd1, 8'h11, 4'd4);
    i_cmd_valid = 1'b1;
    wait_ready();
    @(posedge clk); #1;
    set_cmd(12'h400, 4'd6, 8'h22, 4'd9);
    wait_ready();
    @(posedge clk); #1;
    i_cmd_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    chk("q_accepts", acc_q.size() - a0, 2);
    chk("q_reads", obs_rd.size() - r0, 8);
    chk("q_bundles", obs_ena.size() - e0, 4);
    if (acc_q.size() - a0 == 2 && obs_rd.size() - r0 == 8 && obs_ena.size() - e0 == 4) begin
      chk("q_accept_gap", acc_q[a0 + 1] - acc_q[a0], 7);
      chk("q_accept_on_final_ena", acc_q[a0 + 1], obs_ena[e0 + 1].cyc);
      chk("q_second_first_read", obs_rd[r0 + 4].cyc, acc_q[a0 + 1] + 1);
      for (int i = 1; i < 8; i++)
        chk("q_reads_ordered", obs_rd[r0 + i].cyc > obs_rd[r0 + i - 1].cyc, 1'b1);
      for (int i = 0; i < 4; i++)
        chk("q_z", obs_ena[e0 + i].z, (i < 2) ? 8'h11 : 8'h22);
    end

    // Reset in the RD1 cycle of band 1.
    e0 = obs_ena.size(); r0 = obs_rd.size();
    send(12'h500, 4'd2, 8'h33, 4'd1);
    repeat (4) @(posedge clk);
    #1;
    chk("abort_in_rd1", o_mem_addr, 12'h503);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("abort_ready", o_cmd_ready, 1'b1);
    chk("abort_busy", o_busy, 1'b0);
    chk("abort_rd_en", o_mem_rd_en, 1'b0);
    chk("abort_ena", o_ena, 1'b0);
    chk("abort_done", o_done, 1'b0);
    chk("abort_texture_data", o_texture_data, 256'd0);
    chk("abort_band", o_band, 4'd0);
    repeat (10) @(posedge clk);
    #1;
    chk("abort_bundles", obs_ena.size() - e0, 1);
    chk("abort_reads", obs_rd.size() - r0, 3);
    nd = 0;
    for (int i = e0; i < obs_ena.size(); i++) if (obs_ena[i].done) nd++;
    chk("abort_no_done", nd, 0);

    // Random commands, random gaps, checked by the model.
    for (int n = 0; n < 30; n++) begin
      send(AW'($urandom), 4'($urandom), 8'($urandom), 4'($urandom));
      repeat ($urandom_range(0, 8)) @(posedge clk);
    end
    repeat (12) @(posedge clk);
    #1;
    chk("model_drained_ena", exp_ena.size(), 0);
    chk("model_drained_rd", exp_rd.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
